// File: rtl/fb_scanout.sv
// Frame-buffer scanout: video-timed BRAM reads, 2-bit palette to RGB,
// sync/blank alignment and front/back buffer swap handshake.
module fb_scanout #(
  parameter int unsigned ROW_STRIDE   = 640,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ACTIVE_H     = 1280,
  parameter int unsigned ACTIVE_V     = 720,
  parameter logic [23:0] HILITE_COLOR = 24'hFF_00_00
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_draw_in,
  output logic [18:0] fb_addr_out,
  output logic        fb_sel_out,
  input  logic [1:0]  fb_data_in,
  input  logic        swap_req_in,
  output logic        swap_ack_out,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic [7:0]  frame_count_out
);

  localparam int unsigned DEPTH = READ_LATENCY + 2;

  logic             in_region;
  logic [18:0]      addr_nxt;
  logic [DEPTH-1:0] hs_d;
  logic [DEPTH-1:0] vs_d;
  logic [DEPTH-1:0] act_d;
  logic [23:0]      pal;
  logic             at_pt;
  logic             pt_q;
  logic             swap_pt;
  logic             do_swap;
  logic             pending;

  assign in_region = (hcount_in < 11'(ACTIVE_H))
                  && (vcount_in < 10'(ACTIVE_V));

  assign addr_nxt = 19'(hcount_in[10:1])
                  + 19'(ROW_STRIDE) * 19'(vcount_in[9:1]);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fb_addr_out <= '0;
    end else if (in_region) begin
      fb_addr_out <= addr_nxt;
    end
  end

  // Controls ride alongside the address/BRAM/palette path.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hs_d  <= '0;
      vs_d  <= '0;
      act_d <= '0;
    end else begin
      hs_d  <= {hs_d[DEPTH-2:0], hsync_in};
      vs_d  <= {vs_d[DEPTH-2:0], vsync_in};
      act_d <= {act_d[DEPTH-2:0], active_draw_in};
    end
  end

  assign hsync_out  = hs_d[DEPTH-1];
  assign vsync_out  = vs_d[DEPTH-1];
  assign active_out = act_d[DEPTH-1];

  always_comb begin
    pal = 24'h00_00_00;
    unique case (fb_data_in)
      2'b00: pal = 24'h00_00_00;
      2'b01: pal = 24'h11_11_11;
      2'b10: pal = 24'h77_77_77;
      2'b11: pal = HILITE_COLOR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      {red_out, green_out, blue_out} <= '0;
    end else if (act_d[DEPTH-2]) begin
      {red_out, green_out, blue_out} <= pal;
    end else begin
      {red_out, green_out, blue_out} <= '0;
    end
  end

  // Swap only on the first cycle of the vblank start position.
  assign at_pt   = (vcount_in == 10'(ACTIVE_V))
                && (hcount_in == 11'd0);
  assign swap_pt = at_pt && !pt_q;
  assign do_swap = swap_pt && (pending || swap_req_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pt_q            <= 1'b0;
      pending         <= 1'b0;
      fb_sel_out      <= 1'b0;
      swap_ack_out    <= 1'b0;
      frame_count_out <= '0;
    end else begin
      pt_q         <= at_pt;
      swap_ack_out <= do_swap;
      if (swap_pt) begin
        pending <= 1'b0;
      end else if (swap_req_in) begin
        pending <= 1'b1;
      end
      if (do_swap) begin
        fb_sel_out      <= ~fb_sel_out;
        frame_count_out <= frame_count_out + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: pixel path against a
// pixel-level reference model, and the buffer swap handshake.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        active = 1'b0;
  logic [18:0] fb_addr;
  logic        fb_sel;
  logic [1:0]  fb_data;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [7:0]  red, green, blue;
  logic        hsync_o, vsync_o, active_o;
  logic [7:0]  frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  logic       ovr_en = 1'b0;
  logic [1:0] ovr_code = 2'b00;
  logic [1:0] q0 = '0, q1 = '0;

  fb_scanout dut (
    .clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync),
    .active_draw_in(active),
    .fb_addr_out(fb_addr), .fb_sel_out(fb_sel),
    .fb_data_in(fb_data),
    .swap_req_in(swap_req), .swap_ack_out(swap_ack),
    .red_out(red), .green_out(green), .blue_out(blue),
    .hsync_out(hsync_o), .vsync_out(vsync_o),
    .active_out(active_o),
    .frame_count_out(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] code_of(input logic [18:0] a);
    return a[1:0] ^ a[5:4] ^ a[12:11];
  endfunction

  function automatic logic [23:0] palette(input logic [1:0] c);
    case (c)
      2'b00:   return 24'h000000;
      2'b01:   return 24'h111111;
      2'b10:   return 24'h777777;
      default: return 24'hFF0000;
    endcase
  endfunction

  // Two-cycle BRAM stand-in
  always @(posedge clk) begin
    q0 <= ovr_en ? ovr_code : code_of(fb_addr);
    q1 <= q0;
  end
  assign fb_data = q1;

  always @(negedge clk) if (swap_ack) ack_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input bit hs,
                       input bit vs, input bit act, input bit req);
    hcount   = 11'(h);
    vcount   = 10'(v);
    hsync    = hs;
    vsync    = vs;
    active   = act;
    swap_req = req;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic vblank(input bit req_pt);
    drive(1300, 719, 0, 0, 0, 0); tick();
    drive(0, 720, 0, 1, 0, req_pt); tick();
    drive(1, 720, 0, 1, 0, 0); tick();
    tick();
  endtask

  task automatic pulse_req(input int v);
    drive(200, v, 0, 0, 1, 1); tick();
    drive(201, v, 0, 0, 1, 0); tick();
  endtask

  task automatic test_reset();
    drive(6, 4, 1, 1, 1, 1);
    rst = 1'b1;
    repeat (4) tick();
    n_tests++;
    if ({red, green, blue, hsync_o, vsync_o, active_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_pixel: got %h %b%b%b want 0",
               {red, green, blue}, hsync_o, vsync_o, active_o);
    end
    n_tests++;
    if ({fb_addr, fb_sel, swap_ack, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: addr %0d sel %b ack %b fc %0d want 0",
               fb_addr, fb_sel, swap_ack, frame_count);
    end
    drive(1300, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_pixel();
    do_reset();
    ovr_en = 1'b1;
    ovr_code = 2'b10;
    drive(6, 4, 0, 0, 1, 0); tick();
    n_tests++;
    if (fb_addr !== 19'd1283) begin
      n_fail++;
      $display("FAIL addr_6_4: got %0d want 1283", fb_addr);
    end
    drive(1300, 4, 0, 0, 0, 0);
    tick(); tick();
    n_tests++;
    if ({red, green, blue} !== 24'h0) begin
      n_fail++;
      $display("FAIL early_rgb: got %h want 000000", {red, green, blue});
    end
    tick();
    n_tests++;
    if ({red, green, blue} !== 24'h777777) begin
      n_fail++;
      $display("FAIL rgb_lat4: got %h want 777777", {red, green, blue});
    end
    ovr_en = 1'b0;
  endtask

  task automatic test_palette_sync();
    logic [23:0] seen [0:7];
    logic [23:0] want [0:3];
    int n;
    want[0] = 24'h000000; want[1] = 24'h111111;
    want[2] = 24'h777777; want[3] = 24'hFF0000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(2 * i, 0, 0, 0, 1, 0);
      else drive(1300, 0, 0, 0, 0, 0);
      tick();
      seen[i] = {red, green, blue};
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (seen[i + 3] !== want[i]) begin
        n_fail++;
        $display("FAIL palette_%0d: got %h want %h", i, seen[i + 3], want[i]);
      end
    end
    repeat (5) tick();
    drive(1300, 0, 1, 0, 0, 0);
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      if (hsync_o) break;
    end
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL hsync_delay: got %0d cycles want 4", n);
    end
    drive(1300, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random_pixels();
    localparam int N = 400;
    logic [23:0] e_rgb [0:N-1];
    logic [2:0]  e_ctl [0:N-1];
    logic [18:0] last_addr;
    int h, v, bad;
    bit hs, vs, act;
    do_reset();
    last_addr = '0;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      h = $urandom_range(0, 1400);
      v = $urandom_range(0, 767);
      hs = 1'($urandom);
      vs = 1'($urandom);
      act = 1'($urandom);
      if (h < 1280 && v < 720) last_addr = 19'(h / 2 + 640 * (v / 2));
      e_rgb[k] = act ? palette(code_of(last_addr)) : 24'h0;
      e_ctl[k] = {hs, vs, act};
      drive(h, v, hs, vs, act, 0);
      tick();
      if (k >= 3) begin
        n_tests++;
        if ({red, green, blue} !== e_rgb[k-3]
            || {hsync_o, vsync_o, active_o} !== e_ctl[k-3]) begin
          n_fail++;
          if (bad < 5)
            $display("FAIL rand_pix_%0d: got %h %b want %h %b", k,
                     {red, green, blue}, {hsync_o, vsync_o, active_o},
                     e_rgb[k-3], e_ctl[k-3]);
          bad++;
        end
      end
    end
    drive(1300, 0, 0, 0, 0, 0);
  endtask

  task automatic test_swap_basic();
    int a0;
    do_reset();
    a0 = ack_cnt;
    pulse_req(300);
    n_tests++;
    if (fb_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_mid_frame: got %b want 0", fb_sel);
    end
    vblank(0);
    n_tests++;
    if (fb_sel !== 1'b1 || frame_count !== 8'd1 || ack_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL swap_basic: sel %b fc %0d acks %0d want 1 1 1",
               fb_sel, frame_count, ack_cnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = ack_cnt;
    pulse_req(100); pulse_req(200); pulse_req(400);
    vblank(0);
    n_tests++;
    if (fb_sel !== 1'b0 || frame_count !== 8'd2 || ack_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL swap_absorb: sel %b fc %0d acks %0d want 0 2 1",
               fb_sel, frame_count, ack_cnt - a0);
    end
    a0 = ack_cnt;
    drive(50, 300, 0, 0, 1, 0); tick();
    vblank(0);
    n_tests++;
    if (fb_sel !== 1'b0 || frame_count !== 8'd2 || ack_cnt !== a0) begin
      n_fail++;
      $display("FAIL no_req_frame: sel %b fc %0d acks %0d want 0 2 0",
               fb_sel, frame_count, ack_cnt - a0);
    end
  endtask

  task automatic test_req_at_point();
    int a0;
    a0 = ack_cnt;
    vblank(1);
    n_tests++;
    if (fb_sel !== 1'b1 || frame_count !== 8'd3 || ack_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL req_at_pt: sel %b fc %0d acks %0d want 1 3 1",
               fb_sel, frame_count, ack_cnt - a0);
    end
    a0 = ack_cnt;
    vblank(0);
    n_tests++;
    if (fb_sel !== 1'b1 || ack_cnt !== a0) begin
      n_fail++;
      $display("FAIL req_at_pt_next: sel %b acks %0d want 1 0",
               fb_sel, ack_cnt - a0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int a0;
    pulse_req(300);
    drive(10, 500, 1, 0, 1, 0);
    rst = 1'b1;
    tick(); tick();
    n_tests++;
    if (fb_sel !== 1'b0 || frame_count !== 8'd0
        || {red, green, blue} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset: sel %b fc %0d rgb %h want 0 0 0",
               fb_sel, frame_count, {red, green, blue});
    end
    rst = 1'b0;
    a0 = ack_cnt;
    vblank(0);
    n_tests++;
    if (fb_sel !== 1'b0 || ack_cnt !== a0) begin
      n_fail++;
      $display("FAIL dropped_pending: sel %b acks %0d want 0 0",
               fb_sel, ack_cnt - a0);
    end
  endtask

  task automatic test_random_swaps();
    bit m_sel;
    int m_fc, m_ack, a0, np;
    bit pt;
    do_reset();
    m_sel = 0; m_fc = 0; m_ack = 0;
    a0 = ack_cnt;
    for (int f = 0; f < 24; f++) begin
      np = $urandom_range(0, 3);
      pt = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < np; i++) pulse_req(100 + 50 * i);
      drive(20, 600, 0, 0, 1, 0); tick();
      n_tests++;
      if (fb_sel !== m_sel) begin
        n_fail++;
        $display("FAIL sel_active_%0d: got %b want %b", f, fb_sel, m_sel);
      end
      if (np > 0 || pt) begin
        m_sel = ~m_sel;
        m_fc = (m_fc + 1) % 256;
        m_ack++;
      end
      vblank(pt);
      n_tests++;
      if (fb_sel !== m_sel || frame_count !== 8'(m_fc)
          || ack_cnt - a0 !== m_ack) begin
        n_fail++;
        $display("FAIL rand_swap_%0d: sel %b fc %0d acks %0d want %b %0d %0d",
                 f, fb_sel, frame_count, ack_cnt - a0, m_sel, m_fc, m_ack);
      end
    end
  endtask

  task automatic test_count_wrap();
    int a0;
    do_reset();
    a0 = ack_cnt;
    for (int i = 0; i < 256; i++) begin
      pulse_req(100);
      vblank(0);
      if (i == 254) begin
        n_tests++;
        if (frame_count !== 8'd255) begin
          n_fail++;
          $display("FAIL fc_255: got %0d want 255", frame_count);
        end
      end
    end
    n_tests++;
    if (frame_count !== 8'd0 || fb_sel !== 1'b0 || ack_cnt - a0 !== 256) begin
      n_fail++;
      $display("FAIL fc_wrap: fc %0d sel %b acks %0d want 0 0 256",
               frame_count, fb_sel, ack_cnt - a0);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_palette_sync();
    test_random_pixels();
    test_swap_basic();
    test_back_to_back();
    test_req_at_point();
    test_reset_mid_frame();
    test_random_swaps();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
